// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end feeding decode.
//
// Generates sequential word-aligned PCs, issues them to instruction memory over a
// valid/ready request channel, collects in-order responses of arbitrary latency into a
// DEPTH-entry circular queue of {pc, instr, data_ok} slots, and hands completed entries
// to decode in program order. A redirect from execute flushes the queue and restarts
// fetch. Responses that were already owed to flushed requests are counted and discarded.
//
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   imem_req_*        - fetch request channel (valid/ready, word address)
//   imem_resp_*       - in-order response channel (valid, 32-bit instruction)
//   id_*              - decode channel (valid/ready, pc and instruction of head entry)
//   redirect_*        - flush and restart fetch at redirect_pc (bits [1:0] ignored)
module fetch_queue #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int unsigned    PW      = $clog2(DEPTH);
   localparam int unsigned    CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] slot_pc_q    [DEPTH];
   logic [31:0]     slot_instr_q [DEPTH];
   logic [DEPTH-1:0] slot_ok_q;
   logic [PW-1:0]   alloc_ptr_q, fill_ptr_q, head_ptr_q;
   logic [CW-1:0]   count_q, drop_cnt_q;

   logic            issue, pop, fill, drop;
   logic [CW-1:0]   filled_cnt, pending, redirect_drop, count_d;
   logic [CW:0]     outstanding;

   // Low address bits of the redirect target are forced to zero.
   logic unused_redirect_bits;
   assign unused_redirect_bits = ^redirect_pc[1:0];

   always_comb begin
      imem_req_valid = !reset && !redirect_valid && (count_q < DEPTH_C);
      imem_req_addr  = fetch_pc_q;
      issue          = imem_req_valid && imem_req_ready;

      id_valid = !reset && (count_q != '0) && slot_ok_q[head_ptr_q];
      id_pc    = reset ? '0 : slot_pc_q[head_ptr_q];
      id_instr = reset ? '0 : slot_instr_q[head_ptr_q];
      pop      = id_valid && id_ready;

      fill = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
      drop = imem_resp_valid && (drop_cnt_q != '0) && !redirect_valid;

      // data_ok is only ever set on allocated slots and cleared on pop/flush, so the
      // allocated-but-unfilled slots are exactly count minus the data_ok population.
      filled_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         filled_cnt = filled_cnt + CW'(slot_ok_q[i]);
      end
      pending       = count_q - filled_cnt;
      outstanding   = {1'b0, pending} + {1'b0, drop_cnt_q};
      // A response landing in the redirect cycle is discarded, so it is no longer owed.
      redirect_drop = drop_cnt_q + pending - CW'(imem_resp_valid);
      count_d       = count_q + CW'(issue) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset || redirect_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_pc_q[i]    <= '0;
            slot_instr_q[i] <= '0;
         end
         slot_ok_q   <= '0;
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
         end else begin
            fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_q <= redirect_drop;
         end
      end else begin
         // Issue, fill and pop always touch distinct slots: the alloc slot is free, the
         // fill slot is allocated but unfilled, the head slot being popped is filled.
         if (pop) begin
            slot_pc_q[head_ptr_q]    <= '0;
            slot_instr_q[head_ptr_q] <= '0;
            slot_ok_q[head_ptr_q]    <= 1'b0;
            head_ptr_q               <= head_ptr_q + PW'(1);
         end
         if (issue) begin
            slot_pc_q[alloc_ptr_q]    <= fetch_pc_q;
            slot_instr_q[alloc_ptr_q] <= '0;
            slot_ok_q[alloc_ptr_q]    <= 1'b0;
            alloc_ptr_q               <= alloc_ptr_q + PW'(1);
            fetch_pc_q                <= fetch_pc_q + XLEN'(4);
         end
         if (fill) begin
            slot_instr_q[fill_ptr_q] <= imem_resp_data;
            slot_ok_q[fill_ptr_q]    <= 1'b1;
            fill_ptr_q               <= fill_ptr_q + PW'(1);
         end
         if (drop) begin
            drop_cnt_q <= drop_cnt_q - CW'(1);
         end
         count_q <= count_d;
      end
   end

`ifndef SYNTHESIS
   count_bound_a : assert property (@(posedge clk) disable iff (reset)
      count_q <= DEPTH_C);
   outstanding_bound_a : assert property (@(posedge clk) disable iff (reset)
      outstanding <= (CW + 1)'(DEPTH));
   no_spurious_resp_a : assert property (@(posedge clk) disable iff (reset)
      !(imem_resp_valid && (outstanding == '0)));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req_valid, imem_req_ready = 1'b1;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        id_valid, id_ready = 1'b1;
   logic [63:0] id_pc;
   logic [31:0] id_instr;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(64), .RESET_PC(64'd0), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_pc           (id_pc),
      .id_instr        (id_instr),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   typedef struct { logic [63:0] pc; bit filled; } exp_t;
   typedef struct { logic [63:0] addr; int due; int epoch; } mreq_t;

   exp_t        exp_q[$];   // scoreboard: allocated entries in program order
   mreq_t       mem_q[$];   // memory model: accepted requests awaiting response
   int          vectors = 0, miscompares = 0;
   int          cyc = 0, lat = 1, epoch = 0, pops = 0;
   int          rel_cyc = 0, first_idv = -1;
   logic [63:0] exp_fetch = 64'd0;

   function automatic logic [31:0] instr_of(logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A3C_0F11;
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic tick();
      bit    exp_rv, exp_idv;
      mreq_t r;
      if (reset) begin
         imem_resp_valid = 1'b0;
      end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(mem_q[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
      end
      #1;
      exp_rv  = !reset && !redirect_valid && (exp_q.size() < DEPTH);
      exp_idv = !reset && (exp_q.size() > 0) && exp_q[0].filled;
      check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) check("req_addr", imem_req_addr, exp_fetch);
      check("id_valid", 64'(id_valid), 64'(exp_idv));
      if (exp_idv) begin
         check("id_pc", id_pc, exp_q[0].pc);
         check("id_instr", 64'(id_instr), 64'(instr_of(exp_q[0].pc)));
      end else if (reset || exp_q.size() == 0) begin
         check("id_pc_idle", id_pc, 64'd0);
         check("id_instr_idle", 64'(id_instr), 64'd0);
      end
      if (id_valid && first_idv < 0) first_idv = cyc - rel_cyc;

      if (reset) begin
         exp_q.delete();
         mem_q.delete();
         epoch++;
         exp_fetch = 64'd0;
      end else begin
         if (exp_idv && id_ready) begin
            void'(exp_q.pop_front());
            pops++;
         end
         if (imem_resp_valid) begin
            r = mem_q.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
               for (int i = 0; i < exp_q.size(); i++) begin
                  if (!exp_q[i].filled) begin
                     exp_q[i].filled = 1'b1;
                     break;
                  end
               end
            end
         end
         if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            exp_fetch = {redirect_pc[63:2], 2'b00};
         end else if (exp_rv && imem_req_ready) begin
            exp_q.push_back('{pc: exp_fetch, filled: 1'b0});
            mem_q.push_back('{addr: exp_fetch, due: cyc + lat, epoch: epoch});
            exp_fetch = exp_fetch + 64'd4;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      run(n);
      reset = 1'b0;
      rel_cyc = cyc;
      first_idv = -1;
   endtask

   task automatic do_redirect(logic [63:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      bit found;
      int p0;
      @(negedge clk);

      // 1-cycle memory, always-ready decode: first id_valid 2 cycles after reset low.
      lat = 1;
      do_reset(3);
      run(10);
      check("first_latency", 64'(first_idv), 64'd2);
      p0 = pops;
      run(10);
      check("throughput", 64'(pops - p0), 64'd10);

      // Decode stalled, 3-cycle memory: queue fills and requests stop.
      do_reset(2);
      lat = 3;
      id_ready = 1'b0;
      run(10);
      check("full_stall", 64'(imem_req_valid), 64'd0);
      id_ready = 1'b1;
      run(15);

      // Redirect with three responses outstanding.
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (mem_q.size() == 3) found = 1'b1;
         else tick();
      end
      check("wait_three_outstanding", 64'(found), 64'd1);
      do_redirect(64'h100);
      run(15);

      // Redirect coinciding with a response and a decode handshake; unaligned target.
      lat = 1;
      run(6);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (id_valid && mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
         else tick();
      end
      check("wait_resp_and_pop", 64'(found), 64'd1);
      do_redirect(64'h203);
      run(12);

      // Address wrap at the top of the address space.
      do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
      run(12);

      // Reset mid-stream with a slow memory.
      lat = 3;
      run(5);
      do_reset(1);
      run(15);

      // Randomised traffic with occasional redirects.
      for (int i = 0; i < 400; i++) begin
         imem_req_ready = ($urandom_range(0, 3) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         lat            = $urandom_range(1, 4);
         if ($urandom_range(0, 29) == 0) begin
            do_redirect({32'd0, $urandom()});
         end else begin
            tick();
         end
      end
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      run(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of instruction decode.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel.
- Accepts in-order responses of arbitrary latency and buffers {PC, instruction} pairs in a DEPTH-entry in-order queue.
- Presents entries to decode over a valid/ready handshake; a redirect from execute (taken branch/jump) flushes all in-flight work.

Parameters:
XLEN, 64, PC and address width
RESET_PC, 64'd0, first fetch address after reset
DEPTH, 4, queue entries and maximum outstanding requests; power of two, at least 2

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock and a synchronous active-high reset are fixed for this block
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  fetch address (word aligned)
imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance
imem_resp_data  input  32  instruction word
id_valid  output  1  head entry valid for decode
id_ready  input  1  decode consumes head
id_pc  output  XLEN  PC of head entry
id_instr  output  32  instruction of head entry
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored and treated as 0

Behaviour:
- State:
  - fetch_pc.
  - Circular queue of DEPTH slots {pc, instr, data_ok}.
  - alloc_ptr: next slot to allocate at issue.
  - fill_ptr: next slot to receive a response.
  - head_ptr: next slot to hand to decode.
  - count: allocated slots, range 0..DEPTH.
  - drop_cnt: stale responses still to discard, range 0..DEPTH.
- Reset:
  - fetch_pc=RESET_PC; all pointers, count, drop_cnt and slot contents = 0.
  - Outputs during and right after reset: imem_req_valid=0, id_valid=0, id_pc=0, id_instr=0.
- Issue:
  - imem_req_valid = !reset && !redirect_valid && (count < DEPTH); imem_req_addr = fetch_pc.
  - On acceptance (valid && ready), in the same edge: allocate the slot at alloc_ptr with pc=fetch_pc and data_ok=0; fetch_pc += 4, modulo 2^XLEN; alloc_ptr++.
  - The first request is offered in the first cycle with reset low.
- Fill:
  - If imem_resp_valid && drop_cnt==0 && !redirect_valid, write instr into slot fill_ptr, set data_ok=1, fill_ptr++.
  - If imem_resp_valid && drop_cnt>0 && !redirect_valid, discard the response and drop_cnt--.
- Output:
  - id_valid = (count>0) && data_ok[head_ptr]; id_pc and id_instr come from slot head_ptr.
  - Decode may see id_valid one cycle after the response edge at the earliest, so minimum request-to-decode latency is 2 cycles with 1-cycle memory.
  - On id_valid && id_ready: clear the head slot, head_ptr++, count--.
  - id_pc and id_instr stay stable while id_valid && !id_ready.
- Full: with count==DEPTH, no issue, even if a pop happens in the same cycle (no pop-to-issue bypass).
- Simultaneous issue and pop: count stays unchanged.
- Redirect (has priority over issue and fill):
  - Any id handshake in the same cycle completes; decode has consumed it.
  - Then all slots are cleared, all pointers and count go to 0, fetch_pc=redirect_pc with [1:0] forced to 0.
  - drop_cnt = (existing drop_cnt) + (allocated slots with data_ok==0) − (imem_resp_valid ? 1 : 0). A response arriving in the redirect cycle is discarded.
  - The first request to the new PC is offered the next cycle.
  - Requests may issue while drop_cnt>0; in-order return guarantees stale responses arrive first.
- Back-to-back redirects: each recomputes drop_cnt as above.
- Reset mid-operation: the state is cleared immediately. Responses still owed by memory are the memory's responsibility; the memory model must also reset.
- Invariants, checked by assertions:
  - count ≤ DEPTH.
  - Outstanding responses (non-data_ok allocated slots + drop_cnt) ≤ DEPTH.
  - Never imem_resp_valid when nothing is outstanding.

Test Plan:
- Reset, then 1-cycle memory with imem_req_ready=1 and id_ready=1: requests at 0,4,8,...; first id_valid 2 cycles after reset low with id_pc=0; one instruction per cycle thereafter.
- id_ready=0 with 3-cycle memory: 4 requests issue (0,4,8,C), then imem_req_valid=0. Assert id_ready: pops in order 0,4,8,C; a new request to 0x10 issues the cycle after count drops to 3.
- Redirect to 0x100 with 3 responses outstanding: those 3 responses are dropped, nothing reaches decode; next id_pc=0x100, then 0x104.
- Redirect on the same cycle as a response and an id handshake: the handshaked entry is consumed once, the concurrent response is dropped, and drop_cnt equals remaining outstanding.
- redirect_pc=0x203: fetch restarts at 0x200.
- fetch_pc=2^64−4: the next request is to address 0 (wrap). Reset asserted mid-stream: outputs go to 0 next cycle and fetch restarts at RESET_PC.
